// File: rtl/position_collector_pkg.sv
// ---------------------------------------------------------------------------
// position_collector_pkg
// Shared definitions for the position collector:
//   - default node count and coordinate width
//   - id_width(): width of a node index, at least one bit
//   - state_t: collector state machine encoding (IDLE, PRESENT, DONE)
// ---------------------------------------------------------------------------
package position_collector_pkg;

   localparam int NODE_COUNT_DEF = 5;
   localparam int COORD_W_DEF    = 32;

   // A single-node build still needs a one-bit id port.
   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/position_collector_pending_picker.sv
// ---------------------------------------------------------------------------
// pending_picker
// Combinational priority picker: returns the lowest set index of a vector.
// Ports:
//   pending  in   N      candidate vector
//   idx      out  ID_W   lowest set index (0 when nothing is set)
//   any      out  1      at least one bit set
// ---------------------------------------------------------------------------
module pending_picker #(
   parameter int N    = 5,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    pending,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   always_comb begin
      idx = '0;
      any = |pending;
      // Scan from the top so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/position_collector.sv
// ---------------------------------------------------------------------------
// position_collector
// Collects per-node (x, y) step results and streams them out one beat per
// node per frame, lowest pending index first. When every node has been
// delivered, a one-cycle frame_done pulse closes the frame.
// Ports:
//   clk         in   1                   clock, rising edge
//   reset       in   1                   asynchronous active-high reset
//   finish      in   NODE_COUNT          per-node "result ready" level
//   x_pos       in   NODE_COUNT*COORD_W  packed x, node i at [i*COORD_W +: COORD_W]
//   y_pos       in   NODE_COUNT*COORD_W  packed y, same packing
//   out_valid   out  1                   beat available
//   out_ready   in   1                   consumer accepts beat
//   out_id      out  ID_W                node index of the beat
//   out_x       out  COORD_W             captured x
//   out_y       out  COORD_W             captured y
//   frame_done  out  1                   all nodes delivered this frame (pulse)
//   overrun     out  1                   sticky: a delivered node finished again
// ---------------------------------------------------------------------------
module position_collector
   import position_collector_pkg::*;
#(
   parameter int NODE_COUNT = NODE_COUNT_DEF,
   parameter int COORD_W    = COORD_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NODE_COUNT-1:0]         finish,
   input  logic [NODE_COUNT*COORD_W-1:0] x_pos,
   input  logic [NODE_COUNT*COORD_W-1:0] y_pos,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [id_width(NODE_COUNT)-1:0] out_id,
   output logic [COORD_W-1:0]            out_x,
   output logic [COORD_W-1:0]            out_y,
   output logic                          frame_done,
   output logic                          overrun
);

   localparam int ID_W = id_width(NODE_COUNT);

   state_t                  state_reg, state_next;
   logic [NODE_COUNT-1:0]   pending_reg, pending_next;
   logic [NODE_COUNT-1:0]   reported_reg, reported_next;
   logic                    overrun_reg, overrun_next;
   logic [ID_W-1:0]         out_id_reg;
   logic [COORD_W-1:0]      out_x_reg, out_y_reg;

   logic [COORD_W-1:0]      hold_x [NODE_COUNT];
   logic [COORD_W-1:0]      hold_y [NODE_COUNT];

   logic [NODE_COUNT-1:0]   reported_eff;
   logic [NODE_COUNT-1:0]   cap_mask;
   logic                    ovr_hit;
   logic                    xfer;
   logic [NODE_COUNT-1:0]   xfer_mask;
   logic [NODE_COUNT-1:0]   pick_vec;
   logic [ID_W-1:0]         pick_idx;
   logic                    pick_any;
   logic                    load;

   // The DONE cycle already belongs to the next frame: reported is being
   // cleared on this edge, so finishes seen now are new-frame captures.
   assign reported_eff = (state_reg == DONE) ? '0 : reported_reg;
   assign cap_mask     = finish & ~pending_reg & ~reported_eff;
   assign ovr_hit      = |(finish & reported_eff);

   assign xfer      = (state_reg == PRESENT) && out_ready;
   assign xfer_mask = xfer ? (NODE_COUNT'(1) << out_id_reg) : '0;

   // Removing the beat being transferred lets the same picker choose the
   // back-to-back successor; in IDLE the mask is zero.
   assign pick_vec = pending_reg & ~xfer_mask;

   pending_picker #(
      .N    (NODE_COUNT),
      .ID_W (ID_W)
   ) u_picker (
      .pending (pick_vec),
      .idx     (pick_idx),
      .any     (pick_any)
   );

   // Per-node hold registers: no reset, only read after a capture.
   generate
      for (genvar gi = 0; gi < NODE_COUNT; gi++) begin : g_hold
         always_ff @(posedge clk) begin
            if (cap_mask[gi]) begin
               hold_x[gi] <= x_pos[gi*COORD_W +: COORD_W];
               hold_y[gi] <= y_pos[gi*COORD_W +: COORD_W];
            end
         end
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      pending_next  = (pending_reg | cap_mask) & ~xfer_mask;
      reported_next = reported_reg | xfer_mask;
      overrun_next  = overrun_reg | ovr_hit;
      load          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next = PRESENT;
               load       = 1'b1;
            end
         end
         PRESENT: begin
            if (xfer) begin
               if (&(reported_reg | xfer_mask)) begin
                  state_next = DONE;
               end else if (pick_any) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DONE: begin
            state_next    = IDLE;
            reported_next = '0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         pending_reg  <= '0;
         reported_reg <= '0;
         overrun_reg  <= 1'b0;
         out_id_reg   <= '0;
         out_x_reg    <= '0;
         out_y_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         pending_reg  <= pending_next;
         reported_reg <= reported_next;
         overrun_reg  <= overrun_next;
         if (load) begin
            out_id_reg <= pick_idx;
            out_x_reg  <= hold_x[pick_idx];
            out_y_reg  <= hold_y[pick_idx];
         end
      end
   end

   assign out_valid  = (state_reg == PRESENT);
   assign frame_done = (state_reg == DONE);
   assign out_id     = out_id_reg;
   assign out_x      = out_x_reg;
   assign out_y      = out_y_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_position_collector.sv
// ---------------------------------------------------------------------------
// tb_position_collector
// Directed scenarios with a beat scoreboard: each expected beat is queued
// when its finish is driven and popped when the DUT transfers a beat.
// ---------------------------------------------------------------------------
module tb_position_collector;

   localparam int N  = 5;
   localparam int CW = 32;
   localparam int IW = 3;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    finish = '0;
   logic [N*CW-1:0] x_pos = '0;
   logic [N*CW-1:0] y_pos = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [IW-1:0]   out_id;
   logic [CW-1:0]   out_x;
   logic [CW-1:0]   out_y;
   logic            frame_done;
   logic            overrun;

   int total = 0;
   int bad   = 0;
   int fd_cnt = 0;
   beat_t sb_q[$];

   position_collector #(.NODE_COUNT(N), .COORD_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .finish     (finish),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_x      (out_x),
      .out_y      (out_y),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      finish = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_node(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
      x_pos[i*CW +: CW] = x;
      y_pos[i*CW +: CW] = y;
   endtask

   task automatic push(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
      beat_t b;
      b.id = IW'(i);
      b.x  = x;
      b.y  = y;
      sb_q.push_back(b);
   endtask

   // Beat monitor: a beat seen with out_ready high transfers on the next edge.
   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (!reset && out_valid && out_ready) begin
         check_val("sb_has_beat", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            beat_t b;
            b = sb_q.pop_front();
            check_val("beat_id", 64'(out_id), 64'(b.id));
            check_val("beat_x", 64'(out_x), 64'(b.x));
            check_val("beat_y", 64'(out_y), 64'(b.y));
         end
      end
   end

   initial begin
      int fd_before;

      // ---- asynchronous reset state, before any clock edge ----
      #1 reset = 1'b1;
      #1;
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_id", 64'(out_id), 64'd0);
      check_val("rst_x", 64'(out_x), 64'd0);
      check_val("rst_y", 64'(out_y), 64'd0);
      check_val("rst_fd", 64'(frame_done), 64'd0);
      check_val("rst_ovr", 64'(overrun), 64'd0);
      tick();
      reset = 1'b0;

      // ---- single node, two-edge latency ----
      out_ready = 1'b1;
      set_node(2, 32'h10, 32'h20);
      finish[2] = 1'b1;
      push(2, 32'h10, 32'h20);
      tick();                       // capture edge
      finish = '0;
      check_val("single_lat1_valid", 64'(out_valid), 64'd0);
      tick();                       // IDLE -> PRESENT
      check_val("single_valid", 64'(out_valid), 64'd1);
      check_val("single_id", 64'(out_id), 64'd2);
      tick();                       // transfer
      check_val("single_after_valid", 64'(out_valid), 64'd0);
      check_val("single_no_fd", 64'(fd_cnt), 64'd0);

      // ---- all five together, back-to-back beats then frame_done ----
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         set_node(i, 32'h100 + i, 32'h200 + i);
         push(i, 32'h100 + i, 32'h200 + i);
      end
      finish = '1;
      tick();
      finish = '0;
      for (int i = 0; i < N; i++) begin
         tick();
         check_val($sformatf("all_valid%0d", i), 64'(out_valid), 64'd1);
         check_val($sformatf("all_id%0d", i), 64'(out_id), 64'(i));
      end
      tick();
      check_val("all_fd", 64'(frame_done), 64'd1);
      check_val("all_fd_novalid", 64'(out_valid), 64'd0);
      tick();
      check_val("all_fd_pulse", 64'(frame_done), 64'd0);

      // ---- backpressure: outputs hold, stall capture delivered after id 0 ----
      do_reset();
      out_ready = 1'b0;
      set_node(0, 32'hAA, 32'hBB);
      finish[0] = 1'b1;
      push(0, 32'hAA, 32'hBB);
      tick();
      finish = '0;
      set_node(0, 32'h55, 32'h66);
      tick();
      for (int c = 0; c < 4; c++) begin
         check_val($sformatf("bp_hold_id%0d", c), 64'(out_id), 64'd0);
         check_val($sformatf("bp_hold_x%0d", c), 64'(out_x), 64'hAA);
         if (c == 1) begin
            set_node(3, 32'h33, 32'h44);
            finish[3] = 1'b1;
            push(3, 32'h33, 32'h44);
         end
         tick();
         finish = '0;
         set_node(0, 32'h1000 + c, 32'h2000 + c);
      end
      out_ready = 1'b1;
      tick();                       // id 0 leaves, id 3 loaded same edge
      check_val("bp_next_valid", 64'(out_valid), 64'd1);
      check_val("bp_next_id", 64'(out_id), 64'd3);
      check_val("bp_next_x", 64'(out_x), 64'h33);
      tick();
      check_val("bp_idle", 64'(out_valid), 64'd0);

      // ---- overrun: delivered node finishes again ----
      do_reset();
      out_ready = 1'b1;
      set_node(1, 32'h11, 32'h12);
      finish[1] = 1'b1;
      push(1, 32'h11, 32'h12);
      tick();
      finish = '0;
      tick();
      tick();
      check_val("ovr_before", 64'(overrun), 64'd0);
      finish[1] = 1'b1;
      tick();
      finish = '0;
      check_val("ovr_set", 64'(overrun), 64'd1);
      tick();
      tick();
      check_val("ovr_sticky", 64'(overrun), 64'd1);
      check_val("ovr_no_beat", 64'(out_valid), 64'd0);

      // ---- reset mid-stall ----
      do_reset();
      out_ready = 1'b0;
      set_node(4, 32'h44, 32'h45);
      finish[4] = 1'b1;
      tick();
      finish = '0;
      tick();
      check_val("rs_valid_before", 64'(out_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      check_val("rs_async_valid", 64'(out_valid), 64'd0);
      check_val("rs_async_x", 64'(out_x), 64'd0);
      check_val("rs_async_ovr", 64'(overrun), 64'd0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      fd_before = fd_cnt;
      for (int c = 0; c < 6; c++) tick();
      check_val("rs_no_valid", 64'(out_valid), 64'd0);
      check_val("rs_no_fd", 64'(fd_cnt), 64'(fd_before));

      // ---- frame wrap: finish[0] held through frame_done ----
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i < N; i++) begin
         set_node(i, 32'h300 + i, 32'h400 + i);
         push(i, 32'h300 + i, 32'h400 + i);
      end
      finish = 5'b11110;
      tick();
      finish = '0;
      for (int c = 0; c < 5; c++) tick();  // four beats, back to IDLE
      check_val("wrap_idle", 64'(out_valid), 64'd0);
      set_node(0, 32'h77, 32'h88);
      finish[0] = 1'b1;
      push(0, 32'h77, 32'h88);
      tick();                       // capture
      tick();                       // PRESENT
      tick();                       // transfer -> DONE
      check_val("wrap_fd", 64'(frame_done), 64'd1);
      set_node(0, 32'h99, 32'hAB);
      push(0, 32'h99, 32'hAB);
      tick();                       // DONE edge captures node 0 again
      finish = '0;
      check_val("wrap_ovr0", 64'(overrun), 64'd0);
      tick();
      check_val("wrap_f2_valid", 64'(out_valid), 64'd1);
      check_val("wrap_f2_x", 64'(out_x), 64'h99);
      tick();
      check_val("wrap_ovr1", 64'(overrun), 64'd0);
      check_val("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/position_collector.md
POSITION_COLLECTOR -- requirements
Module: position_collector

Interface
REQ-001 SHALL have parameter NODE_COUNT, default 5: number of nodes reporting results.
REQ-002 SHALL have parameter COORD_W, default 32: width of one coordinate.
REQ-003 SHALL have ports, in this order:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- finish  input  NODE_COUNT  per-node level "step result ready".
- x_pos  input  NODE_COUNT*COORD_W  packed node x coordinates; node i at bits [i*COORD_W +: COORD_W].
- y_pos  input  NODE_COUNT*COORD_W  packed node y coordinates; same packing as x_pos.
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer accepts the beat.
- out_id  output  ID_W  node index of the beat; ID_W = max(1, clog2(NODE_COUNT)).
- out_x  output  COORD_W  captured x coordinate.
- out_y  output  COORD_W  captured y coordinate.
- frame_done  output  1  one-cycle pulse: all nodes have been delivered this frame.
- overrun  output  1  sticky error flag.

Function
REQ-004 SHALL capture x_pos and y_pos of node i into a per-node hold register, and set pending[i], on the edge where finish[i]=1, pending[i]=0 and reported[i]=0.
REQ-005 SHALL ignore finish[i] while pending[i]=1; the hold register SHALL not change.
REQ-006 SHALL set overrun (sticky until reset) on any edge where finish[i]=1 and reported[i]=1, and SHALL ignore that finish.
REQ-007 SHALL use a state machine with states IDLE, PRESENT and DONE.
REQ-008 IDLE -> PRESENT when any pending bit is set. On this transition SHALL load out_id, out_x and out_y from the lowest-index pending node.
REQ-009 A finish sampled at edge n in IDLE SHALL produce out_valid=1 after edge n+1 (latency 2 edges).
REQ-010 In PRESENT, out_valid SHALL be 1.
REQ-011 In PRESENT, out_id, out_x and out_y SHALL hold stable while out_ready=0.
REQ-012 A newly captured lower-index node SHALL NOT preempt the beat currently presented.
REQ-013 A transfer occurs on an edge with out_valid=1 and out_ready=1. On transfer SHALL clear pending[out_id] and set reported[out_id].
REQ-014 On transfer with all reported bits set, including this one, SHALL go to DONE.
REQ-015 On transfer with other pending bits set, SHALL stay in PRESENT and load the next lowest-index pending beat on the same edge, giving back-to-back beats.
REQ-016 On transfer otherwise, SHALL go to IDLE with out_valid=0.
REQ-017 In DONE: frame_done=1 and out_valid=0 for exactly one cycle; reported SHALL clear to all zeros; next state is IDLE.
REQ-018 A finish arriving in the DONE cycle SHALL be captured normally and counts toward the new frame.
REQ-019 Capture SHALL still occur while out_valid=1 and out_ready=0; node results are never dropped by backpressure.
REQ-020 When NODE_COUNT=1, each transfer SHALL lead to DONE.

Reset
REQ-021 Asserting reset SHALL immediately, without waiting for clk, force state IDLE, and clear pending, reported, out_valid, out_id, out_x, out_y, frame_done and overrun to 0.
REQ-022 Reset mid-transfer SHALL discard all held results; no beat or frame_done SHALL be produced for the aborted frame.
REQ-023 Hold registers SHALL need no reset; they are only observable after a capture.

Structure
REQ-024 A shared package SHALL hold the default NODE_COUNT and COORD_W, the ID_W derivation function, and the state enumeration (IDLE, PRESENT, DONE).
REQ-025 A combinational sub-module pending_picker SHALL take a pending vector and return the lowest set index plus an any-set flag; position_collector SHALL instantiate it once.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single node: finish[2]=1 with x=0x10, y=0x20, out_ready=1 -> beat out_id=2, out_x=0x10, out_y=0x20 at the second edge.
- All 5 finish together, out_ready=1 -> beats with ids 0,1,2,3,4 on consecutive cycles, then a frame_done pulse one cycle after the last beat.
- Backpressure: finish[0]=1, out_ready=0 for 4 cycles, x_pos changes meanwhile -> outputs hold the captured values; finish[3] asserted during the stall is delivered after id 0.
- Overrun: node 1 delivered, then finish[1] pulses again before frame_done -> overrun=1 and stays 1; no extra beat for node 1.
- Reset mid-stall: assert reset while out_valid=1 -> out_valid=0 immediately; after release no beat and no frame_done until new finishes arrive.
- Frame wrap: finish[0] held high through the frame_done cycle -> node 0 is captured again and delivered in frame 2 without overrun.
